// File: rtl/video_pattern_gen_pkg.sv
// Shared types and raster helpers for the video pattern generator.
package video_gen_pkg;

   typedef enum logic [1:0] {
      PAT_RAMP,
      PAT_CHECKER,
      PAT_BARS,
      PAT_FCOUNT
   } pattern_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RUN,
      ST_STOP
   } state_e;

   function automatic int h_total(input int w, input int fp,
                                  input int sy, input int bp);
      return w + fp + sy + bp;
   endfunction

   function automatic int v_total(input int h, input int fp,
                                  input int sy, input int bp);
      return h + fp + sy + bp;
   endfunction

   function automatic int cnt_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/video_pattern_gen_if.sv
// Control and pixel-stream bundle between the generator and its sink.
interface video_pattern_gen_if #(
   parameter int DW = 24
);
   logic          i_enable;
   logic [1:0]    i_pattern;
   logic          o_busy;
   logic          o_vsync;
   logic          o_hsync;
   logic          o_data_valid;
   logic          o_sof;
   logic          o_eol;
   logic [DW-1:0] o_data;
   logic [15:0]   o_frame_cnt;

   modport master (
      input  i_enable, i_pattern,
      output o_busy, o_vsync, o_hsync, o_data_valid,
      output o_sof, o_eol, o_data, o_frame_cnt
   );

   modport slave (
      output i_enable, i_pattern,
      input  o_busy, o_vsync, o_hsync, o_data_valid,
      input  o_sof, o_eol, o_data, o_frame_cnt
   );
endinterface

// File: rtl/video_pattern_gen_timing.sv
// Raster counters and decode: h/v position, syncs, active window, x/y.
module video_timing_core
   import video_gen_pkg::*;
#(
   parameter int IMG_WIDTH  = 640,
   parameter int IMG_HEIGHT = 480,
   parameter int H_FP       = 16,
   parameter int H_SYNC     = 96,
   parameter int H_BP       = 48,
   parameter int V_FP       = 10,
   parameter int V_SYNC     = 2,
   parameter int V_BP       = 33,
   localparam int XW = cnt_bits(IMG_WIDTH),
   localparam int YW = cnt_bits(IMG_HEIGHT)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   output logic          active,
   output logic          hs,
   output logic          vs,
   output logic          first,
   output logic          last,
   output logic          frame_end,
   output logic [XW-1:0] x,
   output logic [YW-1:0] y
);
   localparam int HT = h_total(IMG_WIDTH, H_FP, H_SYNC, H_BP);
   localparam int VT = v_total(IMG_HEIGHT, V_FP, V_SYNC, V_BP);
   localparam int HW = cnt_bits(HT);
   localparam int VW = cnt_bits(VT);

   logic [HW-1:0] h_q, h_d;
   logic [VW-1:0] v_q, v_d;
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   int            h_i, v_i;
   logic          h_end, v_end;

   assign h_i   = int'(h_q);
   assign v_i   = int'(v_q);
   assign h_end = (h_i == HT - 1);
   assign v_end = (v_i == VT - 1);

   // x/y track h/v inside the active window and hold past it
   always_comb begin
      h_d = h_q;
      v_d = v_q;
      x_d = x_q;
      y_d = y_q;
      if (!run) begin
         h_d = '0;
         v_d = '0;
         x_d = '0;
         y_d = '0;
      end else if (h_end) begin
         h_d = '0;
         x_d = '0;
         if (v_end) begin
            v_d = '0;
            y_d = '0;
         end else begin
            v_d = v_q + 1'b1;
            if (v_i < IMG_HEIGHT - 1)
               y_d = y_q + 1'b1;
         end
      end else begin
         h_d = h_q + 1'b1;
         if (h_i < IMG_WIDTH - 1)
            x_d = x_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         h_q <= '0;
         v_q <= '0;
         x_q <= '0;
         y_q <= '0;
      end else begin
         h_q <= h_d;
         v_q <= v_d;
         x_q <= x_d;
         y_q <= y_d;
      end
   end

   assign active    = (h_i < IMG_WIDTH) && (v_i < IMG_HEIGHT);
   assign hs        = (h_i >= IMG_WIDTH + H_FP) &&
                      (h_i <  IMG_WIDTH + H_FP + H_SYNC);
   assign vs        = (v_i >= IMG_HEIGHT + V_FP) &&
                      (v_i <  IMG_HEIGHT + V_FP + V_SYNC);
   assign first     = active && (h_i == 0) && (v_i == 0);
   assign last      = active && (h_i == IMG_WIDTH - 1);
   assign frame_end = h_end && v_end;
   assign x         = x_q;
   assign y         = y_q;

endmodule

// File: rtl/video_pattern_gen.sv
// Video test source: run/stop FSM, per-frame pattern latch,
// pattern datapath and registered raster outputs.
module video_pattern_gen
   import video_gen_pkg::*;
#(
   parameter int NUM_CH      = 3,
   parameter int PIXEL_WIDTH = 8,
   parameter int IMG_WIDTH   = 640,
   parameter int IMG_HEIGHT  = 480,
   parameter int H_FP        = 16,
   parameter int H_SYNC      = 96,
   parameter int H_BP        = 48,
   parameter int V_FP        = 10,
   parameter int V_SYNC      = 2,
   parameter int V_BP        = 33,
   parameter bit HS_POL      = 1'b0,
   parameter bit VS_POL      = 1'b0,
   parameter int CHK_LOG2    = 5
) (
   input logic               clk,
   input logic               rst_n,
   video_pattern_gen_if.master vif
);
   localparam int PW    = PIXEL_WIDTH;
   localparam int DW    = NUM_CH * PW;
   localparam int XW    = cnt_bits(IMG_WIDTH);
   localparam int YW    = cnt_bits(IMG_HEIGHT);
   localparam int BAR_W = IMG_WIDTH / 8;

   state_e        state_q;
   logic          busy_q;
   pattern_e      pat_q, pat_d;
   logic [15:0]   fcnt_q, fcnt_d;
   logic          valid_q, valid_d;
   logic          sof_q, sof_d;
   logic          eol_q, eol_d;
   logic          hsync_q, hsync_d;
   logic          vsync_q, vsync_d;
   logic [DW-1:0] data_q, data_d;

   logic          run;
   logic          active, hs, vs, first, last, frame_end;
   logic [XW-1:0] x;
   logic [YW-1:0] y;
   logic [31:0]   xw, yw;
   logic [2:0]    bar;
   logic          chk_on;
   logic [DW-1:0] pix;

   assign run = (state_q != ST_IDLE);

   video_timing_core #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT),
      .H_FP       (H_FP),
      .H_SYNC     (H_SYNC),
      .H_BP       (H_BP),
      .V_FP       (V_FP),
      .V_SYNC     (V_SYNC),
      .V_BP       (V_BP)
   ) u_timing (
      .clk       (clk),
      .rst_n     (rst_n),
      .run       (run),
      .active    (active),
      .hs        (hs),
      .vs        (vs),
      .first     (first),
      .last      (last),
      .frame_end (frame_end),
      .x         (x),
      .y         (y)
   );

   // STOP lets the current frame finish; enable wins at the last cycle
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
      end else begin
         busy_q <= (state_q != ST_IDLE);
         unique case (state_q)
            ST_IDLE:
               if (vif.i_enable) state_q <= ST_RUN;
            ST_RUN:
               if (!vif.i_enable) state_q <= ST_STOP;
            ST_STOP:
               if (vif.i_enable) state_q <= ST_RUN;
               else if (frame_end) state_q <= ST_IDLE;
            default:
               state_q <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      pat_d  = pat_q;
      fcnt_d = fcnt_q;
      if (state_q == ST_IDLE) begin
         if (vif.i_enable)
            pat_d = pattern_e'(vif.i_pattern);
      end else if (frame_end) begin
         pat_d  = pattern_e'(vif.i_pattern);
         fcnt_d = fcnt_q + 16'd1;
      end
   end

   assign xw     = 32'(x);
   assign yw     = 32'(y);
   assign chk_on = xw[CHK_LOG2] ^ yw[CHK_LOG2];

   // bar index by constant thresholds instead of a divider
   always_comb begin
      bar = 3'd0;
      for (int k = 1; k < 8; k++)
         if (xw >= 32'(k * BAR_W))
            bar = bar + 3'd1;
   end

   always_comb begin
      pix = '0;
      for (int c = 0; c < NUM_CH; c++) begin
         unique case (pat_q)
            PAT_RAMP:
               pix[c*PW +: PW] = PW'(xw + yw + (32'(c) << (PW - 2)));
            PAT_CHECKER:
               pix[c*PW +: PW] = {PW{chk_on}};
            PAT_BARS:
               pix[c*PW +: PW] = {PW{bar[c % 3]}};
            PAT_FCOUNT:
               pix[c*PW +: PW] = PW'(fcnt_q);
         endcase
      end
   end

   always_comb begin
      valid_d = run && active;
      sof_d   = run && first;
      eol_d   = run && last;
      hsync_d = (run && hs) ? HS_POL : ~HS_POL;
      vsync_d = (run && vs) ? VS_POL : ~VS_POL;
      data_d  = valid_d ? pix : '0;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pat_q   <= PAT_RAMP;
         fcnt_q  <= '0;
         valid_q <= 1'b0;
         sof_q   <= 1'b0;
         eol_q   <= 1'b0;
         hsync_q <= ~HS_POL;
         vsync_q <= ~VS_POL;
         data_q  <= '0;
      end else begin
         pat_q   <= pat_d;
         fcnt_q  <= fcnt_d;
         valid_q <= valid_d;
         sof_q   <= sof_d;
         eol_q   <= eol_d;
         hsync_q <= hsync_d;
         vsync_q <= vsync_d;
         data_q  <= data_d;
      end
   end

   assign vif.o_busy       = busy_q;
   assign vif.o_vsync      = vsync_q;
   assign vif.o_hsync      = hsync_q;
   assign vif.o_data_valid = valid_q;
   assign vif.o_sof        = sof_q;
   assign vif.o_eol        = eol_q;
   assign vif.o_data       = data_q;
   assign vif.o_frame_cnt  = fcnt_q;

endmodule
